fwd_hazard_sb: RTL and testbench
================================

Name: fwd_hazard_sb

Overview:
Parametrised forwarding-and-interlock unit for the in-order MIPS pipeline. It keeps an internal shadow pipeline of destination tags from E through the last forwarding stage and resolves bypass sources for every source operand of the instruction in D. It raises a combinational interlock stall when the youngest matching producer's result will not be forwardable in time, such as load-use or multi-cycle results. Forward selects for E are registered, so the E-stage mux select is available at cycle start.

Parameters:
- AW, 5: register-index width.
- NSRC, 2: source operands per instruction.
- NFWD, 2: forwarding stages after E. Stage 1 = M, stage 2 = W, and so on.
- SW, $clog2(NFWD+1): width of the forward select and ready-stage fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- hold  in  1  global pipeline freeze, for example memory wait.
- flush_d  in  1  kill the D instruction; it does not enter E.
- d_valid  in  1  D holds a real instruction.
- d_rs  in  NSRC*AW  source register indices, packed, operand 0 in the LSBs.
- d_we  in  1  D instruction writes a register.
- d_rd  in  AW  destination register.
- d_rdy  in  SW  stage (1..NFWD) at whose entry the result becomes forwardable. ALU = 1, load = 2.
- stall  out  1  combinational; holds PC/D and forces a bubble into E.
- e_valid  out  1  registered; E holds a real instruction.
- e_fwd  out  NSRC*SW  registered per-operand select: 0 = register file, k = stage k result.

Behaviour:
- Reset (async, rst_n=0):
  - All shadow entries are invalid.
  - e_valid = 0, e_fwd = 0.
  - stall = 0, because no entries match.
- State: entries 0..NFWD, where entry 0 = E and entry k = stage k. Each entry holds {v, we, rd, rdy}.
- d_rdy is clamped into [1, NFWD] on capture: 0 becomes 1, and values above NFWD become NFWD.
- Matching, per source s:
  - Consider entries i = 0..NFWD-1 with v && we && rd == rs && rs != 0.
  - The lowest i (the youngest producer) wins; older matches are ignored.
  - Entry NFWD is retiring this cycle. The register file is write-before-read, so it is never matched.
- Stall:
  - stall = d_valid && !flush_d && (any s whose winning match has i+1 < rdy).
  - The condition is purely combinational on current state and D inputs.
  - stall is forced to 0 while hold = 1.
- Advance, on each clk edge with hold = 0:
  - Entry k takes entry k-1 for k = 1..NFWD; the old entry NFWD is dropped.
  - Entry 0 takes the D instruction if d_valid && !stall && !flush_d. Otherwise entry 0 becomes a bubble (v = 0).
  - e_valid takes the new entry 0 v bit.
  - e_fwd[s] takes i+1 of the winning match, or 0 if there is no match. It is 0 when a bubble is inserted.
- hold = 1: all state, e_valid and e_fwd are frozen; D inputs are ignored.
- Simultaneous events:
  - hold beats flush_d, which beats stall.
  - flush_d together with a hazard gives stall = 0 and inserts a bubble.
- Latency: a producer with rdy = r forces r-1 stall cycles against an immediately following consumer, and fewer for later consumers.
- Reset asserted mid-operation clears all in-flight tags immediately; no forwarding out of pre-reset state.

Optional Feature:
FWD_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, 32 bits.
  - Reset value 0.
  - Increments by 1 on every clk edge with hold = 0 and stall = 1.
  - Wraps from 0xFFFF_FFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fwd_pkg holds:
  - the shadow-entry struct {v, we, rd, rdy};
  - constants FWD_RF = 0, STG_M = 1, STG_W = 2;
  - the clamp function for d_rdy.
- One sub-module, fwd_match: the per-operand priority matcher. It takes the entries and one rs and returns {hit, idx, notready}. It is instantiated NSRC times.

Test Plan (NSRC=2, NFWD=2):
- ALU back-to-back: issue add $3 (rdy=1), then sub with rs=$3.
  - Required: stall=0 throughout.
  - Required: in the cycle sub is in E, e_valid=1 and e_fwd[0]=1.
- Distance 2: add $3, nop, then or with rt=$3.
  - Required: stall=0.
  - Required: e_fwd[1]=2 when or is in E.
- Load-use: lw $5 (rdy=2), then add with rt=$5.
  - Required: stall=1 for exactly 1 cycle, and the next E cycle has e_valid=0.
  - Required: then add enters E with e_fwd[1]=2.
  - With FWD_STALL_CNT_EN defined, stall_cnt goes 0 -> 1.
- $0 and youngest-wins, two cases:
  - Producer to $0, then consumer of $0 gives stall=0 and e_fwd[0]=0.
  - Producers $7 then $7, then consumer of $7 gives e_fwd[0]=1, from the younger producer.
- hold and flush:
  - Load-use pair with hold=1 for 3 cycles: stall=0 and e_fwd, e_valid, stall_cnt are unchanged. After hold drops, the 1-cycle stall occurs as normal.
  - flush_d=1 alongside the hazard: stall=0 and a bubble enters E.
- Async reset: assert rst_n=0 mid-sequence, between clock edges, with a load in E.
  - Required: e_valid=0 and e_fwd=0 immediately.
  - Required: after release, a consumer of the load's register sees stall=0 and e_fwd=0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/interlock scoreboard.
// Entry fields are sized for the widest supported configuration; modules zero-extend into them.
package fwd_pkg;

  localparam int AW_MAX = 16;
  localparam int SW_MAX = 8;

  localparam int FWD_RF = 0;
  localparam int STG_M  = 1;
  localparam int STG_W  = 2;

  typedef struct packed {
    logic              v;
    logic              we;
    logic [AW_MAX-1:0] rd;
    logic [SW_MAX-1:0] rdy;
  } shadowEntryT;

  // Keep the ready stage inside [M, last forwarding stage].
  function automatic logic [SW_MAX-1:0] clampRdy(input logic [SW_MAX-1:0] rdy,
                                                 input int unsigned nfwd);
    logic [SW_MAX-1:0] lim;
    lim = nfwd[SW_MAX-1:0];
    if (rdy < SW_MAX'(STG_M)) return SW_MAX'(STG_M);
    else if (rdy > lim)       return lim;
    else                      return rdy;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher for one source operand: the youngest in-flight producer of rs wins.
// Reports the forward select it implies and whether that producer is not ready in time.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int AW   = 5,
  parameter int NFWD = 2,
  parameter int SW   = $clog2(NFWD + 1)
) (
  input  shadowEntryT [NFWD-1:0] entries,
  input  logic [AW-1:0]          rs,
  output logic                   hit,
  output logic [SW-1:0]          idx,
  output logic                   notReady
);

  // Scan oldest to youngest so the lowest index overwrites any older match.
  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    notReady = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (entries[i].v && entries[i].we && (entries[i].rd == AW_MAX'(rs)) && (rs != '0)) begin
        hit      = 1'b1;
        idx      = SW'(i + 1);
        notReady = (SW_MAX'(i + 1) < entries[i].rdy);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_sb.sv
// Forwarding-select and load-use interlock unit for the in-order pipeline.
// Optional FWD_STALL_CNT_EN adds a 32-bit stall_cnt output counting stalled advance cycles.
module fwd_hazard_sb
  import fwd_pkg::*;
#(
  parameter int AW   = 5,
  parameter int NSRC = 2,
  parameter int NFWD = 2,
  parameter int SW   = $clog2(NFWD + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 flush_d,
  input  logic                 d_valid,
  input  logic [NSRC*AW-1:0]   d_rs,
  input  logic                 d_we,
  input  logic [AW-1:0]        d_rd,
  input  logic [SW-1:0]        d_rdy,
  output logic                 stall,
  output logic                 e_valid,
  output logic [NSRC*SW-1:0]   e_fwd
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  // Entry k sits in stage k (0 = E). The retiring stage NFWD is never matched, so it is not kept.
  shadowEntryT [NFWD-1:0] ent;
  shadowEntryT            newEntry;

  logic [NSRC-1:0]         hit;
  logic [NSRC-1:0]         notReady;
  logic [NSRC-1:0][SW-1:0] idx;
  logic [NSRC*SW-1:0]      fwdNext;
  logic                    accept;

  for (genvar s = 0; s < NSRC; s++) begin : gMatch
    fwd_match #(
      .AW  (AW),
      .NFWD(NFWD),
      .SW  (SW)
    ) uMatch (
      .entries (ent),
      .rs      (d_rs[s*AW +: AW]),
      .hit     (hit[s]),
      .idx     (idx[s]),
      .notReady(notReady[s])
    );
  end

  // Handshake D->E: the D instruction moves into E on a clock edge with
  // hold=0 when d_valid && !flush_d && !stall; otherwise E receives a bubble.
  // hold freezes everything, so stall is meaningless (and forced low) while it is set.
  assign stall  = !hold && d_valid && !flush_d && (|notReady);
  assign accept = d_valid && !flush_d && !stall;

  always_comb begin
    fwdNext = '0;
    for (int s = 0; s < NSRC; s++) begin
      fwdNext[s*SW +: SW] = hit[s] ? idx[s] : SW'(FWD_RF);
    end
  end

  always_comb begin
    newEntry = '0;
    if (accept) begin
      newEntry.v   = 1'b1;
      newEntry.we  = d_we;
      newEntry.rd  = AW_MAX'(d_rd);
      newEntry.rdy = clampRdy(SW_MAX'(d_rdy), NFWD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent     <= '0;
      e_valid <= 1'b0;
      e_fwd   <= '0;
    end else if (!hold) begin
      for (int k = NFWD - 1; k >= 1; k--) begin
        ent[k] <= ent[k-1];
      end
      ent[0]  <= newEntry;
      e_valid <= accept;
      e_fwd   <= accept ? fwdNext : '0;
    end
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!hold && stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_sb.sv
// Bench for fwd_hazard_sb: directed scenarios then random traffic against an age-based producer model.
module tb_fwd_hazard_sb;

  localparam int AW   = 5;
  localparam int NSRC = 2;
  localparam int NFWD = 2;
  localparam int SW   = 2;

  logic               clk;
  logic               rst_n;
  logic               hold;
  logic               flush_d;
  logic               d_valid;
  logic [NSRC*AW-1:0] d_rs;
  logic               d_we;
  logic [AW-1:0]      d_rd;
  logic [SW-1:0]      d_rdy;
  logic               stall;
  logic               e_valid;
  logic [NSRC*SW-1:0] e_fwd;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]        stall_cnt;
`endif

  fwd_hazard_sb #(.AW(AW), .NSRC(NSRC), .NFWD(NFWD), .SW(SW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .flush_d  (flush_d),
    .d_valid  (d_valid),
    .d_rs     (d_rs),
    .d_we     (d_we),
    .d_rd     (d_rd),
    .d_rdy    (d_rdy),
    .stall    (stall),
    .e_valid  (e_valid),
    .e_fwd    (e_fwd)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: each issued writer is remembered with the advance count at which it sat in E.
  typedef struct {
    int          n;
    logic [4:0]  rd;
    int          rdy;
  } prod_t;

  prod_t       prods[$];
  int          adv;
  logic        expEValid;
  logic [3:0]  expEFwd;
  logic [31:0] expCnt;

  logic        obsStall;
  logic        obsEValid;
  logic [3:0]  obsEFwd;

  function automatic int clampModel(input int r);
    if (r < 1) return 1;
    if (r > NFWD) return NFWD;
    return r;
  endfunction

  // A consumer in D now reaches E at advance adv+1, when producer n is in stage adv+1-n.
  function automatic void resolve(input logic [4:0] rs, output logic hazard, output logic [1:0] sel);
    int bestN;
    int bestRdy;
    hazard  = 1'b0;
    sel     = 2'd0;
    bestN   = -1;
    bestRdy = 0;
    foreach (prods[j]) begin
      int stg;
      stg = adv + 1 - prods[j].n;
      if (rs != 5'd0 && prods[j].rd == rs && stg >= 1 && stg <= NFWD - 1 + 1 && stg <= NFWD
          && prods[j].n > bestN) begin
        bestN   = prods[j].n;
        bestRdy = prods[j].rdy;
      end
    end
    if (bestN >= 0) begin
      sel    = 2'(adv + 1 - bestN);
      hazard = (adv + 1 - bestN) < bestRdy;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    prods.delete();
    adv       = 0;
    expEValid = 1'b0;
    expEFwd   = 4'd0;
    expCnt    = 32'd0;
  endtask

  // driver task: one D-stage presentation, checked before and after the clock edge
  task automatic step(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic we, input logic [4:0] rd, input logic [1:0] rdy,
                      input logic hld, input logic fl);
    logic       hz0, hz1, expStall, acc;
    logic [1:0] s0, s1;
    d_valid = v;
    d_rs    = {rs1, rs0};
    d_we    = we;
    d_rd    = rd;
    d_rdy   = rdy;
    hold    = hld;
    flush_d = fl;
    #1;
    while (prods.size() > 0 && prods[0].n + NFWD < adv + 1) void'(prods.pop_front());
    resolve(rs0, hz0, s0);
    resolve(rs1, hz1, s1);
    expStall = !hld && v && !fl && (hz0 || hz1);
    obsStall = stall;
    check("stall", {31'd0, stall}, {31'd0, expStall});
    @(posedge clk);
    #1;
    if (!hld) begin
      acc = v && !fl && !expStall;
      if (expStall) expCnt++;
      expEValid = acc;
      expEFwd   = acc ? {s1, s0} : 4'd0;
      if (acc && we) prods.push_back('{n: adv + 1, rd: rd, rdy: clampModel(int'(rdy))});
      adv++;
    end
    obsEValid = e_valid;
    obsEFwd   = e_fwd;
    check("e_valid", {31'd0, e_valid}, {31'd0, expEValid});
    check("e_fwd", {28'd0, e_fwd}, {28'd0, expEFwd});
`ifdef FWD_STALL_CNT_EN
    check("stall_cnt", stall_cnt, expCnt);
`endif
    @(negedge clk);
  endtask

  task automatic nops(input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    hold    = 1'b0;
    flush_d = 1'b0;
    d_valid = 1'b0;
    d_rs    = '0;
    d_we    = 1'b0;
    d_rd    = '0;
    d_rdy   = '0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_e_valid", {31'd0, e_valid}, 32'd0);
    check("rst_e_fwd", {28'd0, e_fwd}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
`ifdef FWD_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // ALU back-to-back
    step(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0);
    step(1'b1, 5'd3, 5'd4, 1'b1, 5'd6, 2'd1, 1'b0, 1'b0);
    check("alu_stall", {31'd0, obsStall}, 32'd0);
    check("alu_evalid", {31'd0, obsEValid}, 32'd1);
    check("alu_fwd0", {30'd0, obsEFwd[1:0]}, 32'd1);

    // distance two
    nops(3);
    step(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0);
    nops(1);
    step(1'b1, 5'd4, 5'd3, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0);
    check("dist2_stall", {31'd0, obsStall}, 32'd0);
    check("dist2_fwd1", {30'd0, obsEFwd[3:2]}, 32'd2);

    // load-use
    nops(3);
    step(1'b1, 5'd1, 5'd0, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0);
    step(1'b1, 5'd2, 5'd5, 1'b1, 5'd9, 2'd1, 1'b0, 1'b0);
    check("lu_stall", {31'd0, obsStall}, 32'd1);
    check("lu_bubble", {31'd0, obsEValid}, 32'd0);
    step(1'b1, 5'd2, 5'd5, 1'b1, 5'd9, 2'd1, 1'b0, 1'b0);
    check("lu_stall_done", {31'd0, obsStall}, 32'd0);
    check("lu_fwd1", {30'd0, obsEFwd[3:2]}, 32'd2);

    // $0 is never forwarded; youngest producer wins
    nops(3);
    step(1'b1, 5'd1, 5'd0, 1'b1, 5'd0, 2'd2, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 2'd1, 1'b0, 1'b0);
    check("r0_stall", {31'd0, obsStall}, 32'd0);
    check("r0_fwd0", {30'd0, obsEFwd[1:0]}, 32'd0);
    nops(3);
    step(1'b1, 5'd1, 5'd0, 1'b1, 5'd7, 2'd2, 1'b0, 1'b0);
    step(1'b1, 5'd2, 5'd0, 1'b1, 5'd7, 2'd1, 1'b0, 1'b0);
    step(1'b1, 5'd7, 5'd0, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0);
    check("young_fwd0", {30'd0, obsEFwd[1:0]}, 32'd1);

    // hold across a load-use pair
    nops(3);
    step(1'b1, 5'd1, 5'd0, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd2, 5'd5, 1'b1, 5'd9, 2'd1, 1'b1, 1'b0);
      check("hold_stall", {31'd0, obsStall}, 32'd0);
      check("hold_evalid", {31'd0, obsEValid}, 32'd1);
    end
    step(1'b1, 5'd2, 5'd5, 1'b1, 5'd9, 2'd1, 1'b0, 1'b0);
    check("hold_after_stall", {31'd0, obsStall}, 32'd1);
    step(1'b1, 5'd2, 5'd5, 1'b1, 5'd9, 2'd1, 1'b0, 1'b0);
    check("hold_after_fwd1", {30'd0, obsEFwd[3:2]}, 32'd2);

    // flush beats stall
    nops(3);
    step(1'b1, 5'd1, 5'd0, 1'b1, 5'd5, 2'd2, 1'b0, 1'b0);
    step(1'b1, 5'd2, 5'd5, 1'b1, 5'd9, 2'd1, 1'b0, 1'b1);
    check("flush_stall", {31'd0, obsStall}, 32'd0);
    check("flush_bubble", {31'd0, obsEValid}, 32'd0);

    // asynchronous reset with a load in E
    nops(3);
    step(1'b1, 5'd1, 5'd0, 1'b1, 5'd9, 2'd2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_e_valid", {31'd0, e_valid}, 32'd0);
    check("arst_e_fwd", {28'd0, e_fwd}, 32'd0);
    modelReset();
    #1;
    rst_n = 1'b1;
    step(1'b1, 5'd9, 5'd9, 1'b1, 5'd4, 2'd1, 1'b0, 1'b0);
    check("arst_cons_stall", {31'd0, obsStall}, 32'd0);
    check("arst_cons_fwd", {28'd0, obsEFwd}, 32'd0);

    // random traffic over a small register set so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
